// File: rtl/fsm16bit_pc_sp_if.sv
// fsm16bit_pc_sp_if: stack, program-counter and ALU signal bundle
interface fsm16bit_pc_sp_if;
  logic        push, pop;
  logic [15:0] sp_out;
  logic        save_address_from_instr_mem, save_address_from_data_mem, save_address_from_counter;
  logic [15:0] address_from_instr_mem, address_from_data_mem, address_from_counter_pc;
  logic [15:0] pc_out;
  logic        start, mov_enable;
  logic [5:0]  op_code;
  logic [15:0] a, b;
  logic        bin, cin;
  logic [15:0] result, remainder;
  logic        bout, cout, busy;
  logic        overflow_flag, carry_flag, negative_flag, zero_flag;
  modport master (
    output push, pop, save_address_from_instr_mem, save_address_from_data_mem, save_address_from_counter,
           address_from_instr_mem, address_from_data_mem, address_from_counter_pc,
           start, mov_enable, op_code, a, b, bin, cin,
    input  sp_out, pc_out, result, remainder, bout, cout, busy,
           overflow_flag, carry_flag, negative_flag, zero_flag
  );
  modport slave (
    input  push, pop, save_address_from_instr_mem, save_address_from_data_mem, save_address_from_counter,
           address_from_instr_mem, address_from_data_mem, address_from_counter_pc,
           start, mov_enable, op_code, a, b, bin, cin,
    output sp_out, pc_out, result, remainder, bout, cout, busy,
           overflow_flag, carry_flag, negative_flag, zero_flag
  );
endinterface

// File: rtl/fsm16bit_pc_sp.sv
// fsm16bit_pc_sp: stack pointer, program counter and ALU with multi-cycle MUL/DIV
module fsm16bit_pc_sp #(
  parameter logic [15:0] STACK_TOP    = 16'h01FF,
  parameter logic [15:0] STACK_BOTTOM = 16'h0100
) (
  input logic            clk,
  input logic            rst,
  fsm16bit_pc_sp_if.slave bus
);
  localparam logic [5:0] OP_ADD = 6'h01, OP_SUB = 6'h02, OP_MUL = 6'h03, OP_DIV = 6'h04;
  localparam logic [5:0] OP_AND = 6'h05, OP_OR = 6'h06, OP_XOR = 6'h07, OP_NOT = 6'h08;
  localparam logic [5:0] OP_LSL = 6'h09, OP_LSR = 6'h0A, OP_ROL = 6'h0B, OP_ROR = 6'h0C;
  localparam logic [5:0] OP_CMP = 6'h0D, OP_INC = 6'h0E, OP_DEC = 6'h0F;
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state, state_nx;
  logic [15:0] sp, pc, res, rem, sc_val, fin;
  logic        bout, cout, z_f, n_f, c_f, v_f;
  logic        go, sc_hit, sc_wr, sc_c, sc_v, ge;
  logic [3:0]  cnt;
  logic [31:0] acc, mcand, acc_nx, rotl, rotr;
  logic [15:0] mplier, part, quo, dvsr, quo_nx;
  logic [16:0] add17, sub17, inc17, dec17, lsl17, lsr17, shifted, rem_nx;
  always_ff @(posedge clk)
    if (rst) sp <= STACK_TOP;
    else if (bus.push && !bus.pop && sp != STACK_BOTTOM) sp <= sp - 16'd1;
    else if (bus.pop && !bus.push && sp != STACK_TOP) sp <= sp + 16'd1;
  always_ff @(posedge clk)
    if (rst) pc <= '0;
    else if (bus.save_address_from_instr_mem) pc <= {7'b0, bus.address_from_instr_mem[8:0]};
    else if (bus.save_address_from_data_mem) pc <= bus.address_from_data_mem;
    else if (bus.save_address_from_counter) pc <= bus.address_from_counter_pc;
  assign go = bus.start && !bus.mov_enable;
  always_comb begin
    state_nx = state;
    if (state == IDLE)
      state_nx = !go ? IDLE : bus.op_code == OP_MUL ? MUL : bus.op_code == OP_DIV ? DIV : IDLE;
    else if (cnt == 4'hF)
      state_nx = IDLE;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb begin
    add17 = {1'b0, bus.b} + {1'b0, bus.a} + {16'b0, bus.cin};
    sub17 = {1'b0, bus.b} - {1'b0, bus.a} - {16'b0, bus.bin};
    inc17 = {1'b0, bus.b} + 17'd1;
    dec17 = {1'b0, bus.b} - 17'd1;
    lsl17 = {1'b0, bus.b} << bus.a[3:0];
    lsr17 = {bus.b, 1'b0} >> bus.a[3:0];
    rotl  = {bus.b, bus.b} << bus.a[3:0];
    rotr  = {bus.b, bus.b} >> bus.a[3:0];
    sc_hit = 1'b1;
    sc_wr  = 1'b1;
    sc_val = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (bus.op_code)
      OP_ADD: begin
        sc_val = add17[15:0];
        sc_c   = add17[16];
        sc_v   = (bus.a[15] == bus.b[15]) && (add17[15] != bus.b[15]);
      end
      OP_SUB, OP_CMP: begin
        sc_val = sub17[15:0];
        sc_c   = sub17[16];
        sc_v   = (bus.a[15] != bus.b[15]) && (sub17[15] != bus.b[15]);
        sc_wr  = bus.op_code == OP_SUB;
      end
      OP_AND: sc_val = bus.a & bus.b;
      OP_OR:  sc_val = bus.a | bus.b;
      OP_XOR: sc_val = bus.a ^ bus.b;
      OP_NOT: sc_val = ~bus.b;
      OP_LSL: begin sc_val = lsl17[15:0]; sc_c = lsl17[16]; end
      OP_LSR: begin sc_val = lsr17[16:1]; sc_c = lsr17[0]; end
      OP_ROL: sc_val = rotl[31:16];
      OP_ROR: sc_val = rotr[15:0];
      OP_INC: begin sc_val = inc17[15:0]; sc_c = inc17[16]; sc_v = !bus.b[15] && inc17[15]; end
      OP_DEC: begin sc_val = dec17[15:0]; sc_c = dec17[16]; sc_v = bus.b[15] && !dec17[15]; end
      default: begin sc_hit = 1'b0; sc_wr = 1'b0; end
    endcase
  end
  // one shift-add or one restoring-subtract step per busy cycle
  always_comb begin
    acc_nx  = mplier[0] ? acc + mcand : acc;
    shifted = {part, quo[15]};
    ge      = shifted >= {1'b0, dvsr};
    rem_nx  = ge ? shifted - {1'b0, dvsr} : shifted;
    quo_nx  = {quo[14:0], ge};
    fin     = state == MUL ? acc_nx[15:0] : quo_nx;
  end
  always_ff @(posedge clk)
    if (rst) begin
      {res, rem, bout, cout, z_f, n_f, c_f, v_f} <= '0;
      {acc, mcand, mplier, part, quo, dvsr, cnt} <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
      if (bus.start && bus.mov_enable) begin
        res <= bus.b;
        z_f <= bus.b == 16'd0;
        n_f <= bus.b[15];
        c_f <= 1'b0;
        v_f <= 1'b0;
      end else if (go && bus.op_code == OP_MUL) begin
        acc    <= '0;
        mcand  <= {16'b0, bus.a};
        mplier <= bus.b;
      end else if (go && bus.op_code == OP_DIV) begin
        part <= '0;
        quo  <= bus.b;
        dvsr <= bus.a;
      end else if (bus.start && sc_hit) begin
        if (sc_wr) res <= sc_val;
        z_f <= sc_val == 16'd0;
        n_f <= sc_val[15];
        c_f <= sc_c;
        v_f <= sc_v;
        if (bus.op_code == OP_ADD || bus.op_code == OP_INC) cout <= sc_c;
        if (bus.op_code == OP_SUB || bus.op_code == OP_CMP || bus.op_code == OP_DEC) bout <= sc_c;
      end
    end else begin
      cnt <= cnt + 4'd1;
      if (state == MUL) begin
        acc    <= acc_nx;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end else begin
        part <= rem_nx[15:0];
        quo  <= quo_nx;
      end
      if (cnt == 4'hF) begin
        res <= fin;
        z_f <= fin == 16'd0;
        n_f <= fin[15];
        c_f <= 1'b0;
        v_f <= state == MUL ? |acc_nx[31:16] : dvsr == 16'd0;
        if (state == DIV) rem <= rem_nx[15:0];
      end
    end
  assign bus.sp_out        = sp;
  assign bus.pc_out        = pc;
  assign bus.result        = res;
  assign bus.remainder     = rem;
  assign bus.bout          = bout;
  assign bus.cout          = cout;
  assign bus.busy          = state != IDLE;
  assign bus.overflow_flag = v_f;
  assign bus.carry_flag    = c_f;
  assign bus.negative_flag = n_f;
  assign bus.zero_flag     = z_f;
endmodule

// File: tb/tb_fsm16bit_pc_sp.sv
// tb_fsm16bit_pc_sp: directed and random checks against an arithmetic reference model
module tb_fsm16bit_pc_sp;
  localparam logic [15:0] TOP = 16'h01FF, BOT = 16'h0100;
  logic clk = 1'b0, rst = 1'b1;
  fsm16bit_pc_sp_if bus();
  fsm16bit_pc_sp #(.STACK_TOP(TOP), .STACK_BOTTOM(BOT)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_vec = 0, n_err = 0;
  logic [15:0] m_sp, m_pc, m_res, m_rem, p_res, p_rem;
  logic        m_bout, m_cout, m_z, m_n, m_c, m_v, p_v, p_div;
  int          m_cnt;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_flags(input logic [15:0] val, input logic c, input logic v);
    m_z = val == 16'd0;
    m_n = val[15];
    m_c = c;
    m_v = v;
  endtask

  task automatic model_edge();
    logic [15:0] a, b, r;
    int s, ss, sh;
    longint prod;
    logic c;
    a = bus.a; b = bus.b; sh = int'(a[3:0]);
    if (rst) begin
      m_sp = TOP; m_pc = 0; m_res = 0; m_rem = 0; m_bout = 0; m_cout = 0;
      set_flags(16'd0, 1'b0, 1'b0);
      m_z = 0; m_cnt = 0;
      return;
    end
    if (bus.push && !bus.pop && m_sp > BOT) m_sp--;
    else if (bus.pop && !bus.push && m_sp < TOP) m_sp++;
    if (bus.save_address_from_instr_mem) m_pc = bus.address_from_instr_mem % 512;
    else if (bus.save_address_from_data_mem) m_pc = bus.address_from_data_mem;
    else if (bus.save_address_from_counter) m_pc = bus.address_from_counter_pc;
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_res = p_res;
        if (p_div) m_rem = p_rem;
        set_flags(p_res, 1'b0, p_v);
      end
    end else if (bus.start) begin
      if (bus.mov_enable) begin
        m_res = b;
        set_flags(b, 1'b0, 1'b0);
      end else case (bus.op_code)
        6'h01: begin
          s = int'(b) + int'(a) + int'(bus.cin);
          ss = int'($signed(b)) + int'($signed(a)) + int'(bus.cin);
          m_res = 16'(s); m_cout = s > 65535;
          set_flags(m_res, m_cout, ss > 32767 || ss < -32768);
        end
        6'h02, 6'h0D: begin
          s = int'(b) - int'(a) - int'(bus.bin);
          ss = int'($signed(b)) - int'($signed(a)) - int'(bus.bin);
          r = 16'(s); m_bout = s < 0;
          if (bus.op_code == 6'h02) m_res = r;
          set_flags(r, m_bout, ss > 32767 || ss < -32768);
        end
        6'h03: begin
          prod = longint'(b) * longint'(a);
          p_res = 16'(prod); p_v = prod > 65535; p_div = 0; m_cnt = 16;
        end
        6'h04: begin
          p_res = a == 0 ? 16'hFFFF : b / a;
          p_rem = a == 0 ? b : b % a;
          p_v = a == 0; p_div = 1; m_cnt = 16;
        end
        6'h05: begin m_res = a & b; set_flags(m_res, 1'b0, 1'b0); end
        6'h06: begin m_res = a | b; set_flags(m_res, 1'b0, 1'b0); end
        6'h07: begin m_res = a ^ b; set_flags(m_res, 1'b0, 1'b0); end
        6'h08: begin m_res = ~b; set_flags(m_res, 1'b0, 1'b0); end
        6'h09: begin m_res = b << sh; c = 1'(b >> (16 - sh)); set_flags(m_res, sh != 0 && c, 1'b0); end
        6'h0A: begin m_res = b >> sh; c = sh == 0 ? 1'b0 : 1'(b >> (sh - 1)); set_flags(m_res, c, 1'b0); end
        6'h0B: begin r = b; repeat (sh) r = {r[14:0], r[15]}; m_res = r; set_flags(r, 1'b0, 1'b0); end
        6'h0C: begin r = b; repeat (sh) r = {r[0], r[15:1]}; m_res = r; set_flags(r, 1'b0, 1'b0); end
        6'h0E: begin
          s = int'(b) + 1; ss = int'($signed(b)) + 1;
          m_res = 16'(s); m_cout = s > 65535;
          set_flags(m_res, m_cout, ss > 32767);
        end
        6'h0F: begin
          s = int'(b) - 1; ss = int'($signed(b)) - 1;
          m_res = 16'(s); m_bout = s < 0;
          set_flags(m_res, m_bout, ss < -32768);
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    chk("sp", int'(bus.sp_out), int'(m_sp));
    chk("pc", int'(bus.pc_out), int'(m_pc));
    chk("result", int'(bus.result), int'(m_res));
    chk("remainder", int'(bus.remainder), int'(m_rem));
    chk("busy", int'(bus.busy), int'(m_cnt > 0));
    chk("zero", int'(bus.zero_flag), int'(m_z));
    chk("neg", int'(bus.negative_flag), int'(m_n));
    chk("carry", int'(bus.carry_flag), int'(m_c));
    chk("ovf", int'(bus.overflow_flag), int'(m_v));
    chk("cout", int'(bus.cout), int'(m_cout));
    chk("bout", int'(bus.bout), int'(m_bout));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic clear_inputs();
    {bus.push, bus.pop, bus.start, bus.mov_enable, bus.bin, bus.cin} = '0;
    {bus.save_address_from_instr_mem, bus.save_address_from_data_mem, bus.save_address_from_counter} = '0;
    {bus.address_from_instr_mem, bus.address_from_data_mem, bus.address_from_counter_pc} = '0;
    bus.op_code = '0; bus.a = '0; bus.b = '0;
  endtask

  task automatic alu(input logic [5:0] op, input logic [15:0] b, input logic [15:0] a);
    bus.start = 1; bus.op_code = op; bus.b = b; bus.a = a;
    step();
    bus.start = 0;
  endtask

  task automatic wait_idle(output int nb);
    for (nb = 0; bus.busy && nb < 40; nb++) begin
      bus.start = nb == 5;
      bus.op_code = 6'h01;
      step();
    end
    bus.start = 0;
  endtask

  initial begin
    int nb;
    clear_inputs();
    rst = 1; step();
    chk("rst_sp", int'(bus.sp_out), 'h01FF);
    chk("rst_pc", int'(bus.pc_out), 0);
    rst = 0;
    bus.push = 1; step(); chk("push1", int'(bus.sp_out), 'h01FE);
    step(); chk("push2", int'(bus.sp_out), 'h01FD);
    bus.push = 0; bus.pop = 1; step(); chk("pop1", int'(bus.sp_out), 'h01FE);
    step(); step(); chk("pop_at_top", int'(bus.sp_out), 'h01FF);
    bus.pop = 0;
    bus.save_address_from_instr_mem = 1; bus.address_from_instr_mem = 16'hFE05;
    bus.save_address_from_data_mem = 1; bus.address_from_data_mem = 16'h1234;
    step(); chk("pc_instr", int'(bus.pc_out), 'h0005);
    clear_inputs();
    bus.save_address_from_counter = 1; bus.address_from_counter_pc = 16'h0042;
    step(); chk("pc_counter", int'(bus.pc_out), 'h0042);
    clear_inputs();
    alu(6'h01, 16'hFFFF, 16'h0001);
    chk("add_res", int'(bus.result), 0);
    chk("add_cout", int'(bus.cout), 1);
    chk("add_zc", int'({bus.zero_flag, bus.carry_flag, bus.overflow_flag}), 'b110);
    alu(6'h02, 16'h0000, 16'h0001);
    chk("sub_res", int'(bus.result), 'hFFFF);
    chk("sub_bout_n", int'({bus.bout, bus.negative_flag}), 'b11);
    alu(6'h03, 16'd300, 16'd300);
    wait_idle(nb);
    chk("mul_busy_cycles", nb, 16);
    chk("mul_res", int'(bus.result), 'h5F90);
    chk("mul_ovf", int'(bus.overflow_flag), 1);
    alu(6'h04, 16'd100, 16'd7);
    wait_idle(nb);
    chk("div_busy_cycles", nb, 16);
    chk("div_res", int'(bus.result), 14);
    chk("div_rem", int'(bus.remainder), 2);
    alu(6'h04, 16'd100, 16'd0);
    wait_idle(nb);
    chk("div0_res", int'(bus.result), 'hFFFF);
    chk("div0_rem", int'(bus.remainder), 100);
    chk("div0_ovf", int'(bus.overflow_flag), 1);
    bus.mov_enable = 1;
    alu(6'h03, 16'h8000, 16'h0003);
    bus.mov_enable = 0;
    chk("mov_res", int'(bus.result), 'h8000);
    chk("mov_nz", int'({bus.negative_flag, bus.zero_flag, bus.busy}), 'b100);
    alu(6'h04, 16'd5000, 16'd3);
    step(); step();
    rst = 1; step(); rst = 0;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_res", int'(bus.result), 0);
    alu(6'h01, 16'd2, 16'd3);
    chk("after_abort_add", int'(bus.result), 5);
    bus.push = 1;
    repeat (260) step();
    chk("sp_bottom", int'(bus.sp_out), 'h0100);
    bus.push = 0;
    for (int i = 0; i < 2000; i++) begin
      rst = $urandom_range(0, 79) == 0;
      bus.push = 1'($urandom_range(0, 1));
      bus.pop = 1'($urandom_range(0, 1));
      bus.save_address_from_instr_mem = $urandom_range(0, 3) == 0;
      bus.save_address_from_data_mem = $urandom_range(0, 3) == 0;
      bus.save_address_from_counter = $urandom_range(0, 3) == 0;
      bus.address_from_instr_mem = 16'($urandom);
      bus.address_from_data_mem = 16'($urandom);
      bus.address_from_counter_pc = 16'($urandom);
      bus.start = $urandom_range(0, 2) == 0;
      bus.mov_enable = $urandom_range(0, 7) == 0;
      bus.op_code = $urandom_range(0, 4) == 0 ? 6'($urandom) : 6'($urandom_range(1, 15));
      bus.a = $urandom_range(0, 4) == 0 ? 16'($urandom_range(0, 3)) : 16'($urandom);
      bus.b = $urandom_range(0, 4) == 0 ? 16'($urandom_range(0, 1) ? 16'h7FFF : 16'h8000) : 16'($urandom);
      bus.bin = 1'($urandom_range(0, 1));
      bus.cin = 1'($urandom_range(0, 1));
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
